// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: board, cursor, turn and result state feeding the VGA path.
// Latency: cursor moves next cycle; a placed mark shows next cycle, result 9 cycles after placement.
// Backpressure: none; buttons are ignored while busy (CHECK) and dropped, never queued.
// Optional TTT_FRAME_SYNC_EN: sw, cell_select_flag and win_flag are shadowed and updated on frame_tick.
module ttt_game_ctrl #(
  parameter int CURSOR_RESET = 4,
  parameter int FIRST_PLAYER = 1,
  parameter int AUTO_RESTART = 0
) (
  input  logic        clk25,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_place,
  output logic [17:0] sw,
  output logic [8:0]  cell_select_flag,
  output logic [1:0]  win_flag,
  output logic        turn,
  output logic        busy
);

  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_OVER} state_t;

  localparam logic [1:0] ROW_RST  = 2'(CURSOR_RESET / 3);
  localparam logic [1:0] COL_RST  = 2'(CURSOR_RESET % 3);
  localparam logic       TURN_RST = (FIRST_PLAYER == 2);
  localparam logic [7:0] TICK_LAST = 8'(AUTO_RESTART - 1);

  state_t      state, state_nxt;
  logic [17:0] board;
  logic [1:0]  cur_row, cur_col;
  logic        turn_q;
  logic [3:0]  move_cnt;
  logic [2:0]  line_idx;
  logic        win_seen;
  logic [1:0]  win_q;
  logic [7:0]  tick_cnt;

  logic [3:0]  cur_idx;
  logic [1:0]  pcode;
  logic [1:0]  cell_cur;
  logic [11:0] line_sel;
  logic        line_hit;
  logic        auto_hit;

  // FSM strobes consumed by the datapath
  logic do_place, do_restart, mv_up, mv_down, mv_left, mv_right;
  logic end_win, end_draw, end_next;

  // Cells {a,b,c} of each win line: rows, columns, diagonal, anti-diagonal
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  assign cur_idx  = ({2'b00, cur_row} * 4'd3) + {2'b00, cur_col};
  assign pcode    = turn_q ? 2'b10 : 2'b01;
  assign cell_cur = board[{cur_idx, 1'b0} +: 2];
  assign line_sel = line_cells(line_idx);
  assign line_hit = (board[{line_sel[11:8], 1'b0} +: 2] == pcode) &&
                    (board[{line_sel[7:4],  1'b0} +: 2] == pcode) &&
                    (board[{line_sel[3:0],  1'b0} +: 2] == pcode);
  // Auto restart fires on the Nth frame tick counted since entering OVER
  assign auto_hit = (AUTO_RESTART > 0) && frame_tick && (tick_cnt == TICK_LAST);

  // State register
  always_ff @(posedge clk25) begin
    if (reset) state <= S_PLAY;
    else       state <= state_nxt;
  end

  // Next-state and datapath strobes; one button acted on per cycle in PLAY
  always_comb begin
    state_nxt  = state;
    do_place   = 1'b0;
    do_restart = 1'b0;
    mv_up      = 1'b0;
    mv_down    = 1'b0;
    mv_left    = 1'b0;
    mv_right   = 1'b0;
    end_win    = 1'b0;
    end_draw   = 1'b0;
    end_next   = 1'b0;
    case (state)
      S_PLAY: begin
        if (btn_place) begin
          // A place on an occupied cell still consumes the cycle
          if (cell_cur == 2'b00) begin
            do_place  = 1'b1;
            state_nxt = S_CHECK;
          end
        end else if (btn_up)    mv_up    = 1'b1;
        else if (btn_down)      mv_down  = 1'b1;
        else if (btn_left)      mv_left  = 1'b1;
        else if (btn_right)     mv_right = 1'b1;
      end
      S_CHECK: begin
        if (line_idx == 3'd7) begin
          if (win_seen || line_hit) begin
            end_win   = 1'b1;
            state_nxt = S_OVER;
          end else if (move_cnt == 4'd9) begin
            end_draw  = 1'b1;
            state_nxt = S_OVER;
          end else begin
            end_next  = 1'b1;
            state_nxt = S_PLAY;
          end
        end
      end
      S_OVER: begin
        if (btn_place || auto_hit) begin
          do_restart = 1'b1;
          state_nxt  = S_PLAY;
        end
      end
      default: state_nxt = S_PLAY;
    endcase
  end

  // Board, cursor, turn, line scan and result registers
  always_ff @(posedge clk25) begin
    if (reset || do_restart) begin
      board    <= '0;
      cur_row  <= ROW_RST;
      cur_col  <= COL_RST;
      turn_q   <= TURN_RST;
      move_cnt <= '0;
      line_idx <= '0;
      win_seen <= 1'b0;
      win_q    <= 2'b00;
      tick_cnt <= '0;
    end else begin
      if (mv_up)    cur_row <= (cur_row == 2'd0) ? 2'd2 : cur_row - 2'd1;
      if (mv_down)  cur_row <= (cur_row == 2'd2) ? 2'd0 : cur_row + 2'd1;
      if (mv_left)  cur_col <= (cur_col == 2'd0) ? 2'd2 : cur_col - 2'd1;
      if (mv_right) cur_col <= (cur_col == 2'd2) ? 2'd0 : cur_col + 2'd1;
      if (do_place) begin
        board[{cur_idx, 1'b0} +: 2] <= pcode;
        if (move_cnt != 4'd9) move_cnt <= move_cnt + 4'd1;
        line_idx <= '0;
        win_seen <= 1'b0;
      end
      if (state == S_CHECK) begin
        line_idx <= line_idx + 3'd1;
        win_seen <= win_seen | line_hit;
      end
      if (end_win)  win_q <= pcode;
      if (end_draw) win_q <= 2'b11;
      if (end_next) turn_q <= ~turn_q;
      if (end_win || end_draw) tick_cnt <= '0;
      else if (state == S_OVER && frame_tick && tick_cnt != 8'hFF)
        tick_cnt <= tick_cnt + 8'd1;
    end
  end

  assign turn = turn_q;
  assign busy = (state == S_CHECK);

`ifdef TTT_FRAME_SYNC_EN
  logic [17:0] sw_shd;
  logic [8:0]  sel_shd;
  logic [1:0]  win_shd;

  // Display shadows refresh only at vertical blanking to avoid tearing
  always_ff @(posedge clk25) begin
    if (reset) begin
      sw_shd  <= '0;
      sel_shd <= 9'(1) << CURSOR_RESET;
      win_shd <= 2'b00;
    end else if (frame_tick) begin
      sw_shd  <= board;
      sel_shd <= 9'(1) << cur_idx;
      win_shd <= win_q;
    end
  end

  assign sw               = sw_shd;
  assign cell_select_flag = sel_shd;
  assign win_flag         = win_shd;
`else
  assign sw               = board;
  assign cell_select_flag = 9'(1) << cur_idx;
  assign win_flag         = win_q;
`endif

endmodule
